// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types: register index, hazard-controller state, load-use test.
package cpu_types_pkg;

  typedef logic [4:0] regbits_t;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    BUBBLE  = 2'd2,
    HALTED  = 2'd3
  } pipe_ctrl_state_t;

  typedef logic [1:0] bub_cnt_t;

  // Register 0 is hard-wired zero, so a load targeting it can never create a hazard.
  function automatic logic load_use(input logic     ex_dren,
                                    input regbits_t ex_wsel,
                                    input regbits_t rs,
                                    input regbits_t rt);
    return ex_dren && (ex_wsel != '0) && ((ex_wsel == rs) || (ex_wsel == rt));
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard-controller bundle: pipeline status towards the controller, enables/flushes back.
interface pipe_ctrl_if;
  import cpu_types_pkg::*;

  logic     ihit;
  logic     dhit;
  regbits_t id_rs;
  regbits_t id_rt;
  logic     ex_dREN;
  regbits_t ex_wsel;
  logic     ex_jmp;
  logic     mem_dREN;
  logic     mem_dWEN;
  logic     wb_halt;

  logic     pc_en;
  logic     ifid_en;
  logic     idex_en;
  logic     exmem_en;
  logic     memwb_en;
  logic     ifid_flush;
  logic     idex_flush;
  logic     exmem_flush;
  logic     memwb_flush;
  logic     halt_o;

  // Controller side.
  modport master (
    input  ihit, dhit, id_rs, id_rt, ex_dREN, ex_wsel, ex_jmp, mem_dREN, mem_dWEN, wb_halt,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush, halt_o
  );

  // Pipeline side.
  modport slave (
    output ihit, dhit, id_rs, id_rt, ex_dREN, ex_wsel, ex_jmp, mem_dREN, mem_dWEN, wb_halt,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush, halt_o
  );

endinterface

// File: rtl/pipe_ctrl_sat_cnt.sv
// Saturating event counter: increments on inc, sticks at all-ones, cleared by nRST.
module pipe_ctrl_sat_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + ONE;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: enables/flushes are combinational from state and stage status; state moves on CLK.
// Optional PIPE_CTRL_PERF_EN adds saturating stall/flush counters.
module pipe_ctrl
  import cpu_types_pkg::*;
#(
  parameter int LU_BUBBLES = 1,
  parameter int CNT_W      = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  pipe_ctrl_if.master      pif
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  if (LU_BUBBLES < 1 || LU_BUBBLES > 3 || CNT_W < 1) begin : g_param_check
    $error("pipe_ctrl: LU_BUBBLES must be 1..3 and CNT_W >= 1");
  end

  localparam bub_cnt_t LU_EXTRA = bub_cnt_t'(LU_BUBBLES - 1);

  pipe_ctrl_state_t state, state_nxt;
  bub_cnt_t         bub_cnt, bub_cnt_nxt;

  logic memwait;
  logic lu_hazard;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, exmem_flush, memwb_flush;

  assign memwait   = (pif.mem_dREN | pif.mem_dWEN) & ~pif.dhit;
  assign lu_hazard = load_use(pif.ex_dREN, pif.ex_wsel, pif.id_rs, pif.id_rt);

  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    if (!nRST || state == HALTED) begin
      // frozen
    end else if (memwait) begin
      memwb_en    = 1'b1;
      memwb_flush = 1'b1;
    end else if (pif.ex_jmp) begin
      pc_en      = 1'b1;
      ifid_en    = 1'b1;
      ifid_flush = 1'b1;
      idex_en    = 1'b1;
      idex_flush = 1'b1;
      exmem_en   = 1'b1;
      memwb_en   = 1'b1;
    end else if (lu_hazard || bub_cnt != '0) begin
      // A pending bubble count may survive a MEMWAIT detour, so test the count rather than the state.
      idex_en    = 1'b1;
      idex_flush = 1'b1;
      exmem_en   = 1'b1;
      memwb_en   = 1'b1;
    end else if (!pif.ihit) begin
      ifid_en    = 1'b1;
      ifid_flush = 1'b1;
      idex_en    = 1'b1;
      exmem_en   = 1'b1;
      memwb_en   = 1'b1;
    end else begin
      pc_en    = 1'b1;
      ifid_en  = 1'b1;
      idex_en  = 1'b1;
      exmem_en = 1'b1;
      memwb_en = 1'b1;
    end
  end

  always_comb begin
    state_nxt   = state;
    bub_cnt_nxt = bub_cnt;
    if (state == HALTED) begin
      state_nxt = HALTED;
    end else if (pif.wb_halt) begin
      state_nxt   = HALTED;
      bub_cnt_nxt = '0;
    end else if (memwait) begin
      state_nxt = MEMWAIT;
    end else if (pif.ex_jmp) begin
      state_nxt   = RUN;
      bub_cnt_nxt = '0;
    end else if (bub_cnt != '0) begin
      bub_cnt_nxt = bub_cnt - 2'd1;
      state_nxt   = (bub_cnt == 2'd1) ? RUN : BUBBLE;
    end else if (lu_hazard && LU_BUBBLES > 1) begin
      state_nxt   = BUBBLE;
      bub_cnt_nxt = LU_EXTRA;
    end else begin
      state_nxt = RUN;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= RUN;
      bub_cnt <= '0;
    end else begin
      state   <= state_nxt;
      bub_cnt <= bub_cnt_nxt;
    end
  end

  assign pif.pc_en       = pc_en;
  assign pif.ifid_en     = ifid_en;
  assign pif.idex_en     = idex_en;
  assign pif.exmem_en    = exmem_en;
  assign pif.memwb_en    = memwb_en;
  assign pif.ifid_flush  = ifid_flush;
  assign pif.idex_flush  = idex_flush;
  assign pif.exmem_flush = exmem_flush;
  assign pif.memwb_flush = memwb_flush;
  assign pif.halt_o      = (state == HALTED);

`ifdef PIPE_CTRL_PERF_EN
  logic stall_inc;
  logic flush_inc;

  // ifid_flush together with ex_jmp can only come from the branch path.
  assign stall_inc = ~pc_en & (state != HALTED);
  assign flush_inc = ifid_flush & pif.ex_jmp;

  pipe_ctrl_sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .CLK  (CLK),
    .nRST (nRST),
    .inc  (stall_inc),
    .cnt  (stall_cnt)
  );

  pipe_ctrl_sat_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .CLK  (CLK),
    .nRST (nRST),
    .inc  (flush_inc),
    .cnt  (flush_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomised + directed scoreboard bench for pipe_ctrl (LU_BUBBLES=2, narrow counters to reach saturation).
module tb_pipe_ctrl;
  import cpu_types_pkg::*;

  localparam int LU     = 2;
  localparam int CW     = 4;
  localparam int CNTMAX = (1 << CW) - 1;

  logic CLK  = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  pipe_ctrl_if pif();

`ifdef PIPE_CTRL_PERF_EN
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;
`endif

  pipe_ctrl #(.LU_BUBBLES(LU), .CNT_W(CW)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .pif  (pif)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  typedef struct packed {
    logic     nrst, ihit, dhit;
    regbits_t rs, rt;
    logic     ex_dren;
    regbits_t wsel;
    logic     jmp, mren, mwen, halt;
  } stim_t;

  // {pc, ifid_en, idex_en, exmem_en, memwb_en, ifid_fl, idex_fl, exmem_fl, memwb_fl, halt}
  typedef logic [9:0] ctl_t;
  localparam ctl_t C_OFF    = 10'b00000_0000_0;
  localparam ctl_t C_HALT   = 10'b00000_0000_1;
  localparam ctl_t C_MEMW   = 10'b00001_0001_0;
  localparam ctl_t C_JMP    = 10'b11111_1100_0;
  localparam ctl_t C_BUBBLE = 10'b00111_0100_0;
  localparam ctl_t C_NOFETCH= 10'b01111_1000_0;
  localparam ctl_t C_NORMAL = 10'b11111_0000_0;

  typedef struct {
    ctl_t ctl;
    int   stall;
    int   flush;
    int   cyc;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  // Reference model: halted flag plus number of bubble cycles still owed.
  bit m_halted = 0;
  int m_bub    = 0;
  int m_stall  = 0;
  int m_flush  = 0;

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.nrst = 1'b1;
    s.ihit = 1'b1;
    s.dhit = 1'b1;
    return s;
  endfunction

  task automatic step(input stim_t s);
    exp_t e;
    bit   mw, lu;
    @(posedge CLK);
    #1;
    nRST         = s.nrst;
    pif.ihit     = s.ihit;
    pif.dhit     = s.dhit;
    pif.id_rs    = s.rs;
    pif.id_rt    = s.rt;
    pif.ex_dREN  = s.ex_dren;
    pif.ex_wsel  = s.wsel;
    pif.ex_jmp   = s.jmp;
    pif.mem_dREN = s.mren;
    pif.mem_dWEN = s.mwen;
    pif.wb_halt  = s.halt;

    mw = (s.mren || s.mwen) && !s.dhit;
    lu = s.ex_dren && (s.wsel != 0) && (s.wsel == s.rs || s.wsel == s.rt);

    if (!s.nrst) begin
      m_halted = 0; m_bub = 0; m_stall = 0; m_flush = 0;
      e.ctl = C_OFF;
    end else if (m_halted)           e.ctl = C_HALT;
    else if (mw)                     e.ctl = C_MEMW;
    else if (s.jmp)                  e.ctl = C_JMP;
    else if (lu || m_bub > 0)        e.ctl = C_BUBBLE;
    else if (!s.ihit)                e.ctl = C_NOFETCH;
    else                             e.ctl = C_NORMAL;

    e.stall = m_stall;
    e.flush = m_flush;
    e.cyc   = cyc;
    sb_q.push_back(e);
    cyc++;

    if (s.nrst && !m_halted) begin
      if (!e.ctl[9] && m_stall < CNTMAX) m_stall++;
      if (e.ctl == C_JMP && m_flush < CNTMAX) m_flush++;
      if (s.halt) begin
        m_halted = 1; m_bub = 0;
      end else if (mw) begin
        // bubbles owed are kept while memory stalls
      end else if (s.jmp)  m_bub = 0;
      else if (m_bub > 0)  m_bub--;
      else if (lu)         m_bub = LU - 1;
    end
  endtask

  function automatic stim_t rand_stim();
    stim_t s;
    s.nrst    = m_halted ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 99) != 0);
    s.ihit    = ($urandom_range(0, 9) != 0);
    s.dhit    = $urandom_range(0, 1) == 1;
    s.rs      = regbits_t'($urandom_range(0, 3));
    s.rt      = regbits_t'($urandom_range(0, 3));
    s.ex_dren = ($urandom_range(0, 9) < 4);
    s.wsel    = regbits_t'($urandom_range(0, 3));
    s.jmp     = ($urandom_range(0, 99) < 12);
    s.mren    = ($urandom_range(0, 9) < 2);
    s.mwen    = ($urandom_range(0, 9) < 1);
    s.halt    = ($urandom_range(0, 149) == 0);
    return s;
  endfunction

  // Monitor: compares whatever the DUT presents mid-cycle against the oldest expectation.
  initial begin : monitor
    exp_t e;
    ctl_t a;
    forever begin
      @(negedge CLK);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        a = {pif.pc_en, pif.ifid_en, pif.idex_en, pif.exmem_en, pif.memwb_en,
             pif.ifid_flush, pif.idex_flush, pif.exmem_flush, pif.memwb_flush, pif.halt_o};
        n_chk++;
        if (a !== e.ctl) begin
          n_fail++;
          $display("FAIL ctl cycle %0d: got %b want %b", e.cyc, a, e.ctl);
        end
`ifdef PIPE_CTRL_PERF_EN
        n_chk++;
        if (int'(stall_cnt) != e.stall) begin
          n_fail++;
          $display("FAIL stall_cnt cycle %0d: got %0d want %0d", e.cyc, stall_cnt, e.stall);
        end
        n_chk++;
        if (int'(flush_cnt) != e.flush) begin
          n_fail++;
          $display("FAIL flush_cnt cycle %0d: got %0d want %0d", e.cyc, flush_cnt, e.flush);
        end
`endif
      end
    end
  end

  initial begin : driver
    stim_t s, rst;
    rst = '0;
    pif.ihit = 0; pif.dhit = 0; pif.id_rs = 0; pif.id_rt = 0; pif.ex_dREN = 0;
    pif.ex_wsel = 0; pif.ex_jmp = 0; pif.mem_dREN = 0; pif.mem_dWEN = 0; pif.wb_halt = 0;

    step(rst); step(rst);
    step(idle()); step(idle());

    // load-use with two bubbles
    s = idle(); s.ex_dren = 1; s.wsel = 5; s.rs = 5; step(s);
    repeat (3) step(idle());
    // register 0 never hazards
    s = idle(); s.ex_dren = 1; s.wsel = 0; s.rs = 0; s.rt = 0; step(s);
    // memory wait three cycles then advance
    s = idle(); s.mren = 1; s.dhit = 0; repeat (3) step(s);
    s.dhit = 1; step(s); step(idle());
    // branch with fetch miss
    s = idle(); s.jmp = 1; s.ihit = 0; step(s); step(idle());
    // branch wins over load-use, no bubble follows
    s = idle(); s.jmp = 1; s.ex_dren = 1; s.wsel = 7; s.rt = 7; step(s);
    step(idle()); step(idle());
    // memory stall inside a bubble sequence pauses the bubble count
    s = idle(); s.ex_dren = 1; s.wsel = 3; s.rt = 3; step(s);
    s = idle(); s.mwen = 1; s.dhit = 0; step(s); step(s);
    step(idle()); step(idle());
    // branch aborts remaining bubbles
    s = idle(); s.ex_dren = 1; s.wsel = 2; s.rs = 2; step(s);
    s = idle(); s.jmp = 1; step(s); step(idle());
    // halt, stay halted, reset releases
    s = idle(); s.halt = 1; step(s);
    step(idle()); step(idle());
    step(rst); step(idle()); step(idle());
    // reset mid-MEMWAIT and mid-BUBBLE leave no residue
    s = idle(); s.mren = 1; s.dhit = 0; step(s); step(s);
    step(rst);
    s = idle(); s.dhit = 0; step(s); step(idle());
    s = idle(); s.ex_dren = 1; s.wsel = 4; s.rs = 4; step(s);
    step(rst); step(idle());
    // counter saturation
    s = idle(); s.ihit = 0; repeat (CNTMAX + 3) step(s);
    s = idle(); s.jmp = 1; repeat (CNTMAX + 3) step(s);
    step(rst);

    for (int i = 0; i < 3000; i++) step(rand_stim());

    @(posedge CLK);
    @(negedge CLK);
    #1;
    n_chk++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard drain: got %0d pending want 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
